// File: rtl/pc_seq_ctrl_pkg.sv
// pc_seq_ctrl_pkg: shared sequencer state encoding, error codes and reset PC default
package pc_seq_ctrl_pkg;
   typedef enum logic [2:0] {S_IDLE, S_FETCH_REQ, S_FETCH_WAIT, S_EXEC, S_HALTED} state_t;
   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_MISALIGN = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
endpackage

// File: rtl/pc_seq_ctrl_timeout.sv
// pc_seq_ctrl_timeout: fetch-response watchdog, expires when the count reaches TIMEOUT-1
module pc_seq_ctrl_timeout #(
   parameter int TIMEOUT = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] r_cnt;
   assign o_expire = r_cnt == CW'(TIMEOUT - 1);
   // count idle wait cycles, restarting on every new fetch handshake
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_en && !o_expire) r_cnt <= r_cnt + CW'(1);
endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: multi-cycle PC sequencer (fetch, hold for execute, commit); PC_SEQ_TIMEOUT_EN adds a fetch watchdog
module pc_seq_ctrl
   import pc_seq_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = DEF_RESET_PC
`ifdef PC_SEQ_TIMEOUT_EN
   , parameter int TIMEOUT = 256
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  ifu_req_valid,
   input  logic                  ifu_req_ready,
   output logic [ADDR_WIDTH-1:0] ifu_req_addr,
   input  logic                  ifu_rsp_valid,
   output logic                  ifu_rsp_ready,
   input  logic [DATA_WIDTH-1:0] ifu_rsp_data,
   output logic [DATA_WIDTH-1:0] inst,
   output logic                  inst_valid,
   input  logic                  exu_done,
   input  logic [ADDR_WIDTH-1:0] npc,
   input  logic                  trap_req,
   input  logic [ADDR_WIDTH-1:0] trap_pc,
   input  logic                  halt_req,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  retire,
   output logic [63:0]           instret,
   output logic                  halted,
   output logic [1:0]            err
);
   state_t r_state, w_next;
   logic [ADDR_WIDTH-1:0] r_pc, w_target;
   logic [DATA_WIDTH-1:0] r_inst;
   logic [63:0] r_instret;
   logic [1:0] r_err;
   logic r_inst_valid, r_retire;
   logic w_req_fire, w_rsp_fire, w_commit, w_misalign, w_retire, w_redirect, w_expire;

   assign w_req_fire = ifu_req_valid && ifu_req_ready;
   assign w_rsp_fire = ifu_rsp_ready && ifu_rsp_valid;
   assign w_commit = (r_state == S_EXEC) && exu_done;
   assign w_target = trap_req ? trap_pc : npc;
   assign w_misalign = |w_target[1:0];
   assign w_retire = w_commit && (halt_req || !w_misalign);
   assign w_redirect = w_commit && !halt_req && !w_misalign;
   assign ifu_req_addr = r_pc;
   assign pc = r_pc;
   assign inst = r_inst;
   assign instret = r_instret;
   assign err = r_err;
   assign inst_valid = r_inst_valid;
   assign retire = r_retire;

`ifdef PC_SEQ_TIMEOUT_EN
   pc_seq_ctrl_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_req_fire),
      .i_en     (ifu_rsp_ready && !ifu_rsp_valid),
      .o_expire (w_expire)
   );
`else
   assign w_expire = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_state <= S_IDLE;
      else r_state <= w_next;

   // next state: a response wins over a same-cycle watchdog expiry
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:       w_next = S_FETCH_REQ;
         S_FETCH_REQ:  w_next = w_req_fire ? S_FETCH_WAIT : S_FETCH_REQ;
         S_FETCH_WAIT: w_next = ifu_rsp_valid ? S_EXEC : (w_expire ? S_HALTED : S_FETCH_WAIT);
         S_EXEC:       w_next = !exu_done ? S_EXEC : ((halt_req || w_misalign) ? S_HALTED : S_FETCH_REQ);
         default:      w_next = r_state;
      endcase
   end

   // state-decoded handshake and status outputs
   always_comb begin
      ifu_req_valid = r_state == S_FETCH_REQ;
      ifu_rsp_ready = r_state == S_FETCH_WAIT;
      halted = r_state == S_HALTED;
   end

   // architectural PC, instruction latch, retire counter and error code
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_pc <= RESET_PC;
         r_inst <= '0;
         r_instret <= '0;
         r_err <= ERR_NONE;
         r_inst_valid <= 1'b0;
         r_retire <= 1'b0;
      end else begin
         r_inst_valid <= w_rsp_fire;
         r_retire <= w_retire;
         if (w_rsp_fire) r_inst <= ifu_rsp_data;
         if (w_retire) r_instret <= r_instret + 64'd1;
         if (w_redirect) r_pc <= w_target;
         if (w_commit && !halt_req && w_misalign) r_err <= ERR_MISALIGN;
         else if (ifu_rsp_ready && !ifu_rsp_valid && w_expire) r_err <= ERR_TIMEOUT;
      end
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: vector table, corner sequences and random instructions checked against a rule model
module tb_pc_seq_ctrl;
   localparam logic [31:0] RPC = 32'h8000_0000;

   logic clk = 1'b0, rst = 1'b0;
   logic ifu_req_valid, ifu_req_ready = 1'b0, ifu_rsp_valid = 1'b0, ifu_rsp_ready;
   logic [31:0] ifu_req_addr, ifu_rsp_data = '0, inst, npc = '0, trap_pc = '0, pc;
   logic inst_valid, exu_done = 1'b0, trap_req = 1'b0, halt_req = 1'b0, retire, halted;
   logic [63:0] instret;
   logic [1:0] err;

   int n_tests = 0, n_fail = 0;
   logic [31:0] m_pc;
   logic [63:0] m_instret;
   logic m_halted;
   logic [1:0] m_err;

   typedef struct {
      int wreq, wrsp, wexec;
      logic [31:0] data, npc;
      bit tr;
      logic [31:0] tpc;
      bit h;
      logic [31:0] e_pc;
      logic [63:0] e_instret;
   } vec_t;
   vec_t tbl[6];

   always #5 clk = ~clk;

   pc_seq_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(RPC)
`ifdef PC_SEQ_TIMEOUT_EN
      , .TIMEOUT(8)
`endif
   ) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_data(ifu_rsp_data),
      .inst(inst), .inst_valid(inst_valid), .exu_done(exu_done), .npc(npc),
      .trap_req(trap_req), .trap_pc(trap_pc), .halt_req(halt_req),
      .pc(pc), .retire(retire), .instret(instret), .halted(halted), .err(err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic junk_exu();
      exu_done = 1'($urandom_range(0, 1));
      npc = $urandom;
      trap_req = 1'($urandom_range(0, 1));
      trap_pc = $urandom;
      halt_req = 1'($urandom_range(0, 1));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pc"}, pc, RPC);
      check({tag, "_inst"}, inst, 0);
      check({tag, "_instret"}, instret, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_bits"}, {ifu_req_valid, ifu_rsp_ready, inst_valid, retire, halted}, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      ifu_req_ready = 1'b0;
      ifu_rsp_valid = 1'b0;
      junk_exu();
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      rst = 1'b1;
      m_pc = RPC;
      m_instret = 0;
      m_halted = 1'b0;
      m_err = 2'd0;
      check("idle_req", ifu_req_valid, 0);
      @(negedge clk);
   endtask

   task automatic fetch(input int wreq, input int wrsp, input logic [31:0] data, input bit early);
      for (int i = 0; i < wreq; i++) begin
         check("req_hold_valid", ifu_req_valid, 1);
         check("req_hold_addr", ifu_req_addr, m_pc);
         ifu_req_ready = 1'b0;
         junk_exu();
         @(negedge clk);
      end
      check("req_valid", ifu_req_valid, 1);
      check("req_addr", ifu_req_addr, m_pc);
      ifu_req_ready = 1'b1;
      ifu_rsp_valid = early;
      ifu_rsp_data = ~data;
      @(negedge clk);
      ifu_req_ready = 1'b0;
      ifu_rsp_valid = 1'b0;
      for (int i = 0; i < wrsp; i++) begin
         check("wait_state", {ifu_rsp_ready, ifu_req_valid, inst_valid}, 3'b100);
         junk_exu();
         @(negedge clk);
      end
      check("rsp_ready", ifu_rsp_ready, 1);
      ifu_rsp_valid = 1'b1;
      ifu_rsp_data = data;
      exu_done = 1'b0;
      @(negedge clk);
      ifu_rsp_valid = 1'b0;
      check("inst_valid", inst_valid, 1);
      check("inst", inst, data);
      check("exec_pc", pc, m_pc);
   endtask

   task automatic commit(input int wexec, input logic [31:0] n, input bit tr, input logic [31:0] tpc, input bit h);
      logic [31:0] tgt;
      bit ret;
      for (int i = 0; i < wexec; i++) begin
         exu_done = 1'b0;
         @(negedge clk);
         check("exec_hold", {inst_valid, retire, ifu_req_valid}, 0);
      end
      exu_done = 1'b1;
      npc = n;
      trap_req = tr;
      trap_pc = tpc;
      halt_req = h;
      @(negedge clk);
      exu_done = 1'b0;
      tgt = tr ? tpc : n;
      ret = 1'b1;
      if (h) begin
         m_halted = 1'b1;
         m_instret++;
      end else if (tgt % 4 != 0) begin
         m_halted = 1'b1;
         m_err = 2'd1;
         ret = 1'b0;
      end else begin
         m_pc = tgt;
         m_instret++;
      end
      check("commit_pc", pc, m_pc);
      check("commit_retire", retire, ret);
      check("commit_instret", instret, m_instret);
      check("commit_halted", halted, m_halted);
      check("commit_err", err, m_err);
      check("commit_req", ifu_req_valid, !m_halted);
   endtask

   initial begin
      tbl[0] = '{0, 0, 0, 32'h0000_0013, 32'h8000_0004, 1'b0, 32'h0, 1'b0, 32'h8000_0004, 64'd1};
      tbl[1] = '{5, 2, 0, 32'h0010_0093, 32'h8000_0008, 1'b0, 32'h0, 1'b0, 32'h8000_0008, 64'd2};
      tbl[2] = '{1, 0, 1, 32'h0000_0073, 32'h8000_0008, 1'b1, 32'h8000_0100, 1'b0, 32'h8000_0100, 64'd3};
      tbl[3] = '{0, 3, 2, 32'h3020_0073, 32'h8000_0200, 1'b0, 32'h0, 1'b0, 32'h8000_0200, 64'd4};
      tbl[4] = '{2, 1, 0, 32'hdead_beef, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 32'h0000_0000, 64'd5};
      tbl[5] = '{0, 0, 3, 32'h1234_5678, 32'h8000_0007, 1'b1, 32'hffff_fffc, 1'b0, 32'hffff_fffc, 64'd6};
      do_reset();
      foreach (tbl[k]) begin
         fetch(tbl[k].wreq, tbl[k].wrsp, tbl[k].data, k[0]);
         commit(tbl[k].wexec, tbl[k].npc, tbl[k].tr, tbl[k].tpc, tbl[k].h);
         check("tbl_pc", pc, tbl[k].e_pc);
         check("tbl_instret", instret, tbl[k].e_instret);
      end
      // halt beats trap in the same commit
      do_reset();
      fetch(0, 0, 32'h0010_0073, 1'b0);
      commit(0, 32'h8000_0008, 1'b1, 32'h8000_0100, 1'b1);
      check("halt_pc", pc, RPC);
      check("halt_flags", {halted, retire, err}, 4'b1100);
      for (int i = 0; i < 3; i++) begin
         junk_exu();
         ifu_rsp_valid = 1'b1;
         @(negedge clk);
         check("halt_hold", {halted, ifu_req_valid, ifu_rsp_ready, retire, inst_valid}, 5'b10000);
         check("halt_hold_instret", instret, 1);
         check("halt_hold_pc", pc, RPC);
      end
      ifu_rsp_valid = 1'b0;
      // misaligned npc stops without retiring
      do_reset();
      fetch(0, 0, 32'h0000_0013, 1'b0);
      commit(0, 32'h8000_0006, 1'b0, 32'h0, 1'b0);
      check("mis_flags", {halted, retire, err}, 4'b1001);
      check("mis_instret", instret, 0);
      check("mis_pc", pc, RPC);
      // asynchronous reset in the middle of a fetch wait
      do_reset();
      fetch(0, 0, 32'h0000_0013, 1'b0);
      commit(0, 32'h8000_0004, 1'b0, 32'h0, 1'b0);
      ifu_req_ready = 1'b1;
      @(negedge clk);
      ifu_req_ready = 1'b0;
      check("mid_wait", ifu_rsp_ready, 1);
      #2 rst = 1'b0;
      #1 check_reset_outputs("mid_rst");
      @(negedge clk);
      rst = 1'b1;
      m_pc = RPC;
      m_instret = 0;
      m_halted = 1'b0;
      m_err = 2'd0;
      @(negedge clk);
      check("fresh_req", {ifu_req_valid, ifu_req_addr}, {1'b1, RPC});
      fetch(1, 0, 32'h0000_0093, 1'b0);
      commit(0, 32'h8000_0004, 1'b0, 32'h0, 1'b0);
      // randomized instruction stream against the rule model
      do_reset();
      for (int it = 0; it < 60; it++) begin
         logic [31:0] r1, r2;
         if (m_halted) do_reset();
         r1 = $urandom;
         r2 = $urandom;
         if ($urandom_range(0, 7) != 0) r1[1:0] = 2'b00;
         if ($urandom_range(0, 7) != 0) r2[1:0] = 2'b00;
         fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
         commit($urandom_range(0, 2), r1, $urandom_range(0, 3) == 0, r2, $urandom_range(0, 15) == 0);
      end
`ifdef PC_SEQ_TIMEOUT_EN
      do_reset();
      ifu_req_ready = 1'b1;
      @(negedge clk);
      ifu_req_ready = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         check("to_wait", halted, 0);
         @(negedge clk);
      end
      check("to_expire", {halted, err, ifu_rsp_ready}, 4'b1100);
      do_reset();
      ifu_req_ready = 1'b1;
      @(negedge clk);
      ifu_req_ready = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         check("to_wait2", halted, 0);
         @(negedge clk);
      end
      ifu_rsp_valid = 1'b1;
      ifu_rsp_data = 32'h0000_0013;
      @(negedge clk);
      ifu_rsp_valid = 1'b0;
      check("to_late_rsp", {inst_valid, halted, err}, 4'b1000);
      check("to_late_inst", inst, 32'h0000_0013);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
